// File: rtl/cic_comb_chain_if.sv
// Sample stream bundle between the rate-down sampler and the CIC comb chain.
// The master drives clear and samples; the slave returns the comb output and overflow flags.
interface cic_comb_chain_if #(
    parameter int WIDTH = 16
);
    logic                    clr;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_data;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_data;
    logic                    ovf;
    logic                    ovf_sticky;

    modport master (
        output clr, in_valid, in_data,
        input  out_valid, out_data, ovf, ovf_sticky
    );

    modport slave (
        input  clr, in_valid, in_data,
        output out_valid, out_data, ovf, ovf_sticky
    );
endinterface

// File: rtl/cic_comb_chain.sv
// Cascaded CIC comb stages y[n] = x[n] - x[n-M] over valid samples, one register per stage.
// Define COMB_SAT_EN to saturate overflowing stages instead of wrapping.
module cic_comb_chain #(
    parameter int WIDTH      = 16,
    parameter int N_STAGES   = 3,
    parameter int DIFF_DELAY = 1
) (
    input  logic            clk,
    input  logic            rstn,
    cic_comb_chain_if.slave bus
);
`ifdef COMB_SAT_EN
    localparam logic signed [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    // Index s is the input of stage s; index N_STAGES is the chain output.
    logic signed [WIDTH-1:0] w_stageData  [N_STAGES+1];
    logic                    w_stageValid [N_STAGES+1];
    logic                    w_stageOvf   [N_STAGES+1];
    logic                    r_ovfSticky;

    assign w_stageData[0]  = bus.in_data;
    assign w_stageValid[0] = bus.in_valid;
    assign w_stageOvf[0]   = 1'b0;

    for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
        logic signed [WIDTH-1:0] r_delay [DIFF_DELAY];
        logic signed [WIDTH-1:0] r_data;
        logic                    r_valid;
        logic                    r_ovf;
        logic signed [WIDTH-1:0] w_tap;
        logic signed [WIDTH-1:0] w_diff;
        logic signed [WIDTH-1:0] w_result;
        logic                    w_wrap;

        assign w_tap  = r_delay[DIFF_DELAY-1];
        assign w_diff = w_stageData[s] - w_tap;
        assign w_wrap = (w_stageData[s][WIDTH-1] != w_tap[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != w_stageData[s][WIDTH-1]);

`ifdef COMB_SAT_EN
        // The true result always carries the sign of x when wrapping occurs.
        assign w_result = w_wrap ? (w_stageData[s][WIDTH-1] ? SAT_MIN : SAT_MAX) : w_diff;
`else
        assign w_result = w_diff;
`endif

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 0; k < DIFF_DELAY; k++) r_delay[k] <= '0;
                r_data  <= '0;
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (bus.clr) begin
                for (int k = 0; k < DIFF_DELAY; k++) r_delay[k] <= '0;
                r_data  <= '0;
                r_valid <= 1'b0;
                r_ovf   <= 1'b0;
            end else if (w_stageValid[s]) begin
                // Delay line keeps the raw input so saturation never feeds back.
                r_delay[0] <= w_stageData[s];
                for (int k = 1; k < DIFF_DELAY; k++) r_delay[k] <= r_delay[k-1];
                r_data  <= w_result;
                r_valid <= 1'b1;
                r_ovf   <= w_stageOvf[s] | w_wrap;
            end else begin
                r_valid <= 1'b0;
            end
        end

        assign w_stageData[s+1]  = r_data;
        assign w_stageValid[s+1] = r_valid;
        assign w_stageOvf[s+1]   = r_ovf;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovfSticky <= 1'b0;
        end else if (bus.clr) begin
            r_ovfSticky <= 1'b0;
        end else if (bus.out_valid && bus.ovf) begin
            r_ovfSticky <= 1'b1;
        end
    end

    assign bus.out_data   = w_stageData[N_STAGES];
    assign bus.out_valid  = w_stageValid[N_STAGES];
    assign bus.ovf        = w_stageValid[N_STAGES] & w_stageOvf[N_STAGES];
    assign bus.ovf_sticky = r_ovfSticky;
endmodule

// File: tb/tb_cic_comb_chain.sv
// Directed bench for cic_comb_chain: three 8-bit instances (N=1/M=1, N=2/M=1, N=1/M=2)
// share one stimulus stream; each vector checks the instance it targets.
module tb_cic_comb_chain;
    logic       clk;
    logic       tbRstn;
    logic       tbClr;
    logic       tbValid;
    logic [7:0] tbData;

    int compared   = 0;
    int mismatched = 0;

`ifdef COMB_SAT_EN
    localparam logic [7:0] OVF_RESULT = 8'h80;
`else
    localparam logic [7:0] OVF_RESULT = 8'h01;
`endif

    cic_comb_chain_if #(.WIDTH(8)) ifA ();
    cic_comb_chain_if #(.WIDTH(8)) ifB ();
    cic_comb_chain_if #(.WIDTH(8)) ifC ();

    assign ifA.clr = tbClr;  assign ifA.in_valid = tbValid;  assign ifA.in_data = tbData;
    assign ifB.clr = tbClr;  assign ifB.in_valid = tbValid;  assign ifB.in_data = tbData;
    assign ifC.clr = tbClr;  assign ifC.in_valid = tbValid;  assign ifC.in_data = tbData;

    cic_comb_chain #(.WIDTH(8), .N_STAGES(1), .DIFF_DELAY(1)) dutA (.clk(clk), .rstn(tbRstn), .bus(ifA.slave));
    cic_comb_chain #(.WIDTH(8), .N_STAGES(2), .DIFF_DELAY(1)) dutB (.clk(clk), .rstn(tbRstn), .bus(ifB.slave));
    cic_comb_chain #(.WIDTH(8), .N_STAGES(1), .DIFF_DELAY(2)) dutC (.clk(clk), .rstn(tbRstn), .bus(ifC.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         clr;
        bit         valid;
        logic [7:0] data;
        int         dut;
        bit         expValid;
        logic [7:0] expData;
        bit         expOvf;
        bit         expSticky;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(bit rst, bit clr, bit valid, logic [7:0] data, int dut,
                                   bit expValid, logic [7:0] expData, bit expOvf, bit expSticky);
        vec_t v;
        v.rst = rst; v.clr = clr; v.valid = valid; v.data = data; v.dut = dut;
        v.expValid = expValid; v.expData = expData; v.expOvf = expOvf; v.expSticky = expSticky;
        vecs.push_back(v);
    endfunction

    task automatic checkValue(input string label, input logic [7:0] actual, input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", label, actual, expected);
        end
    endtask

    task automatic doReset();
        tbRstn = 1'b0; tbClr = 1'b0; tbValid = 1'b0; tbData = 8'h00;
        #2;
        tbRstn = 1'b1;
    endtask

    task automatic applyStimulus(input bit clr, input bit valid, input logic [7:0] data);
        tbClr = clr; tbValid = valid; tbData = data;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int dut, input bit expValid,
                               input logic [7:0] expData, input bit expOvf, input bit expSticky);
        logic       v, o, s;
        logic [7:0] d;
        case (dut)
            0:       begin v = ifA.out_valid; d = ifA.out_data; o = ifA.ovf; s = ifA.ovf_sticky; end
            1:       begin v = ifB.out_valid; d = ifB.out_data; o = ifB.ovf; s = ifB.ovf_sticky; end
            default: begin v = ifC.out_valid; d = ifC.out_data; o = ifC.ovf; s = ifC.ovf_sticky; end
        endcase
        checkValue({tag, ".valid"}, {7'd0, v}, {7'd0, expValid});
        if (expValid) checkValue({tag, ".data"}, d, expData);
        checkValue({tag, ".ovf"}, {7'd0, o}, {7'd0, expOvf});
        checkValue({tag, ".sticky"}, {7'd0, s}, {7'd0, expSticky});
    endtask

    initial begin
        logic [7:0] gapExp [4];

        // Single first difference of a constant.
        addVec(1, 0, 1, 8'h05, 0, 1, 8'h05, 0, 0);
        addVec(0, 0, 1, 8'h05, 0, 1, 8'h00, 0, 0);
        addVec(0, 0, 1, 8'h05, 0, 1, 8'h00, 0, 0);
        addVec(0, 0, 1, 8'h05, 0, 1, 8'h00, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        // Two-stage impulse response 1,-2,1,0.
        addVec(1, 0, 1, 8'h01, 1, 0, 8'h00, 0, 0);
        addVec(0, 0, 1, 8'h00, 1, 1, 8'h01, 0, 0);
        addVec(0, 0, 1, 8'h00, 1, 1, 8'hFE, 0, 0);
        addVec(0, 0, 1, 8'h00, 1, 1, 8'h01, 0, 0);
        addVec(0, 0, 0, 8'h00, 1, 1, 8'h00, 0, 0);
        addVec(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0);
        // Overflow: -128 - 127, sticky rises a cycle later, clr drops it.
        addVec(1, 0, 1, 8'h7F, 0, 1, 8'h7F, 0, 0);
        addVec(0, 0, 1, 8'h80, 0, 1, OVF_RESULT, 1, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        addVec(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
        // Differential delay 2, then clr drops the coincident sample.
        addVec(1, 0, 1, 8'h0A, 2, 1, 8'h0A, 0, 0);
        addVec(0, 0, 1, 8'h14, 2, 1, 8'h14, 0, 0);
        addVec(0, 0, 1, 8'h1E, 2, 1, 8'h14, 0, 0);
        addVec(0, 0, 1, 8'h28, 2, 1, 8'h14, 0, 0);
        addVec(0, 1, 1, 8'h32, 2, 0, 8'h00, 0, 0);
        addVec(0, 0, 1, 8'h07, 2, 1, 8'h07, 0, 0);
        addVec(0, 0, 0, 8'h00, 2, 0, 8'h00, 0, 0);

        tbRstn = 1'b0; tbClr = 1'b0; tbValid = 1'b0; tbData = 8'h00;
        #12;
        tbRstn = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset", 0, 0, 8'h00, 0, 0);
        checkValue("reset.dataA", ifA.out_data, 8'h00);
        checkValue("reset.dataB", ifB.out_data, 8'h00);
        checkValue("reset.dataC", ifC.out_data, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i].clr, vecs[i].valid, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].dut, vecs[i].expValid,
                        vecs[i].expData, vecs[i].expOvf, vecs[i].expSticky);
        end

        // Impulse with three idle cycles between samples must give the same sequence.
        gapExp[0] = 8'h01; gapExp[1] = 8'hFE; gapExp[2] = 8'h01; gapExp[3] = 8'h00;
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, (i == 0) ? 8'h01 : 8'h00);
            checkOutput($sformatf("gap%0d.edge0", i), 1, 0, 8'h00, 0, 0);
            applyStimulus(0, 0, 8'h00);
            checkOutput($sformatf("gap%0d.edge1", i), 1, 1, gapExp[i], 0, 0);
            applyStimulus(0, 0, 8'h00);
            checkOutput($sformatf("gap%0d.edge2", i), 1, 0, 8'h00, 0, 0);
            applyStimulus(0, 0, 8'h00);
            checkOutput($sformatf("gap%0d.edge3", i), 1, 0, 8'h00, 0, 0);
        end

        // Asynchronous reset with samples in flight clears outputs without a clock edge.
        doReset();
        applyStimulus(0, 1, 8'h09);
        applyStimulus(0, 1, 8'h0B);
        tbValid = 1'b0; tbData = 8'h00;
        #2;
        tbRstn = 1'b0;
        #1;
        checkValue("async.validA", {7'd0, ifA.out_valid}, 8'h00);
        checkValue("async.dataA", ifA.out_data, 8'h00);
        checkValue("async.validB", {7'd0, ifB.out_valid}, 8'h00);
        checkValue("async.dataB", ifB.out_data, 8'h00);
        #2;
        tbRstn = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(0, 1, 8'h2A);
        checkOutput("async.first", 0, 1, 8'h2A, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
